// File: rtl/stopwatch_controller_if.sv
// Signal bundle between the stopwatch board buttons / counter / divider and the controller.
interface stopwatch_controller_if;
  // Buttons are raw, asynchronous, active-high levels. LimitReached is synchronous to Clk.
  // Controls are registered levels, except CounterReset, which is a one-cycle pulse.
  logic       BtnStop;
  logic       BtnUp;
  logic       BtnDown;
  logic       BtnClear;
  logic       BtnFaster;
  logic       BtnSlower;
  logic       LimitReached;
  logic       CounterStop;
  logic       CounterUpDown;
  logic       CounterReset;
  logic [4:0] Speed;
  logic       ModeUp;
  logic       ModeDown;
  logic       ModeLimit;

  modport master (
    output BtnStop, BtnUp, BtnDown, BtnClear, BtnFaster, BtnSlower, LimitReached,
    input  CounterStop, CounterUpDown, CounterReset, Speed, ModeUp, ModeDown, ModeLimit
  );

  modport slave (
    input  BtnStop, BtnUp, BtnDown, BtnClear, BtnFaster, BtnSlower, LimitReached,
    output CounterStop, CounterUpDown, CounterReset, Speed, ModeUp, ModeDown, ModeLimit
  );
endinterface

// File: rtl/stopwatch_controller.sv
// Stopwatch mode/speed sequencer: button sync, optional debounce, press detect, mode FSM, speed.
// Optional filter: define STOPWATCH_CONTROLLER_DEBOUNCE_EN to enable per-button debouncing.
module stopwatch_controller #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SPEED_RESET     = 20
) (
  input  logic                  Clk,
  input  logic                  Reset,
  stopwatch_controller_if.slave bus,
  output logic [1:0]            dbg_state_o
);

  localparam int NB      = 6;
  localparam int B_STOP  = 0;
  localparam int B_UP    = 1;
  localparam int B_DOWN  = 2;
  localparam int B_CLEAR = 3;
  localparam int B_FAST  = 4;
  localparam int B_SLOW  = 5;

  localparam logic [4:0] SPEED_RST = 5'(SPEED_RESET);
  localparam logic [4:0] SPEED_MAX = 5'd31;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (SPEED_RESET < 0 || SPEED_RESET > 31) begin : g_bad_speed
    $error("SPEED_RESET must be in 0..31");
  end

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2,
    LIMIT    = 2'd3
  } state_t;

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1_q;
  logic [NB-1:0] sync2_q;
  logic [NB-1:0] level;
  logic [NB-1:0] prev_q;
  logic [NB-1:0] evt_q;
  logic          limit_q;

  assign btn_raw = {bus.BtnSlower, bus.BtnFaster, bus.BtnClear,
                    bus.BtnDown, bus.BtnUp, bus.BtnStop};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef STOPWATCH_CONTROLLER_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // The level only flips once DEBOUNCE_CYCLES consecutive samples disagree with it.
  for (genvar g = 0; g < NB; g++) begin : g_deb
    logic          lvl_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
        lvl_q <= 1'b0;
        cnt_q <= '0;
      end else if (sync2_q[g] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        lvl_q <= sync2_q[g];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign level[g] = lvl_q;
  end
`else
  assign level = sync2_q;
`endif

  // One press event per rising level; limit is registered so it aligns with button events.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prev_q  <= '0;
      evt_q   <= '0;
      limit_q <= 1'b0;
    end else begin
      prev_q  <= level;
      evt_q   <= level & ~prev_q;
      limit_q <= bus.LimitReached;
    end
  end

  state_t     state_q, state_d;
  logic       dir_q, dir_d;
  logic       clear_d;
  logic [4:0] speed_q, speed_d;
  logic       cstop_q, cud_q, crst_q;
  logic       mode_up_q, mode_down_q, mode_limit_q;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    clear_d = 1'b0;
    // Only the highest-priority event of the cycle is acted on.
    if (evt_q[B_CLEAR]) begin
      state_d = STOPPED;
      dir_d   = 1'b1;
      clear_d = 1'b1;
    end else if (evt_q[B_STOP]) begin
      state_d = STOPPED;
    end else if (evt_q[B_UP]) begin
      if (state_q == STOPPED || state_q == RUN_DOWN || (state_q == LIMIT && !dir_q)) begin
        state_d = RUN_UP;
        dir_d   = 1'b1;
      end
    end else if (evt_q[B_DOWN]) begin
      if (state_q == STOPPED || state_q == RUN_UP || (state_q == LIMIT && dir_q)) begin
        state_d = RUN_DOWN;
        dir_d   = 1'b0;
      end
    end else if (limit_q) begin
      if (state_q == RUN_UP || state_q == RUN_DOWN) begin
        state_d = LIMIT;
      end
    end
  end

  always_comb begin
    speed_d = speed_q;
    if (evt_q[B_FAST] && !evt_q[B_SLOW]) begin
      if (speed_q != 5'd0) speed_d = speed_q - 5'd1;
    end else if (evt_q[B_SLOW] && !evt_q[B_FAST]) begin
      if (speed_q != SPEED_MAX) speed_d = speed_q + 5'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= STOPPED;
      dir_q        <= 1'b1;
      speed_q      <= SPEED_RST;
      cstop_q      <= 1'b1;
      cud_q        <= 1'b1;
      crst_q       <= 1'b0;
      mode_up_q    <= 1'b0;
      mode_down_q  <= 1'b0;
      mode_limit_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      speed_q      <= speed_d;
      cstop_q      <= (state_d == STOPPED) || (state_d == LIMIT);
      cud_q        <= dir_d;
      crst_q       <= clear_d;
      mode_up_q    <= (state_d == RUN_UP);
      mode_down_q  <= (state_d == RUN_DOWN);
      mode_limit_q <= (state_d == LIMIT);
    end
  end

  assign bus.CounterStop   = cstop_q;
  assign bus.CounterUpDown = cud_q;
  assign bus.CounterReset  = crst_q;
  assign bus.Speed         = speed_q;
  assign bus.ModeUp        = mode_up_q;
  assign bus.ModeDown      = mode_down_q;
  assign bus.ModeLimit     = mode_limit_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller: vector table plus latency, limit, clear, speed, reset sequences.
module tb_stopwatch_controller;

  localparam int DEB = 8;
`ifdef STOPWATCH_CONTROLLER_DEBOUNCE_EN
  localparam int EXTRA = DEB;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT  = 3 + EXTRA;
  localparam int HOLD = 5 + EXTRA;
  localparam int GAP  = 6 + EXTRA;
  localparam int TAP  = 2 + EXTRA;

  localparam logic [5:0] B_NONE  = 6'b000000;
  localparam logic [5:0] B_STOP  = 6'b000001;
  localparam logic [5:0] B_UP    = 6'b000010;
  localparam logic [5:0] B_DOWN  = 6'b000100;
  localparam logic [5:0] B_CLEAR = 6'b001000;
  localparam logic [5:0] B_FAST  = 6'b010000;
  localparam logic [5:0] B_SLOW  = 6'b100000;

  // clock / reset
  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] dbg_state;
  always #5 Clk = ~Clk;

  stopwatch_controller_if sw ();

  stopwatch_controller #(.DEBOUNCE_CYCLES(DEB), .SPEED_RESET(20)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .bus         (sw),
    .dbg_state_o (dbg_state)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // {CounterStop, CounterUpDown, ModeUp, ModeDown, ModeLimit, Speed}
  function automatic logic [9:0] obs();
    return {sw.CounterStop, sw.CounterUpDown, sw.ModeUp, sw.ModeDown, sw.ModeLimit, sw.Speed};
  endfunction

  function automatic logic [9:0] ex(input logic s, input logic u, input logic [2:0] m,
                                    input logic [4:0] sp);
    return {s, u, m, sp};
  endfunction

  // drivers
  task automatic set_btn(input logic [5:0] b);
    sw.BtnStop   = b[0];
    sw.BtnUp     = b[1];
    sw.BtnDown   = b[2];
    sw.BtnClear  = b[3];
    sw.BtnFaster = b[4];
    sw.BtnSlower = b[5];
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [5:0] b, input int hi, input int lo);
    set_btn(b);
    cycles(hi);
    set_btn(B_NONE);
    cycles(lo);
  endtask

  typedef struct {
    string      name;
    logic [5:0] btn;
    logic       lim;
    logic [9:0] exp;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(input string n, input logic [5:0] b, input logic l,
                              input logic [9:0] e);
    vec_t v;
    v.name = n;
    v.btn  = b;
    v.lim  = l;
    v.exp  = e;
    return v;
  endfunction

  initial begin
    int pulses;
    int bad_stop;
    logic prev_stop;

    // table starts in RUN_UP at Speed 20
    tbl[0]  = mk("up_in_run_up",       B_UP,          1'b0, ex(0, 1, 3'b100, 5'd20));
    tbl[1]  = mk("down_from_up",       B_DOWN,        1'b0, ex(0, 0, 3'b010, 5'd20));
    tbl[2]  = mk("stop_from_down",     B_STOP,        1'b0, ex(1, 0, 3'b000, 5'd20));
    tbl[3]  = mk("stop_in_stopped",    B_STOP,        1'b0, ex(1, 0, 3'b000, 5'd20));
    tbl[4]  = mk("limit_in_stopped",   B_NONE,        1'b1, ex(1, 0, 3'b000, 5'd20));
    tbl[5]  = mk("up_from_stopped",    B_UP,          1'b0, ex(0, 1, 3'b100, 5'd20));
    tbl[6]  = mk("limit_in_up",        B_NONE,        1'b1, ex(1, 1, 3'b001, 5'd20));
    tbl[7]  = mk("up_in_limit_up",     B_UP,          1'b0, ex(1, 1, 3'b001, 5'd20));
    tbl[8]  = mk("limit_in_limit",     B_NONE,        1'b1, ex(1, 1, 3'b001, 5'd20));
    tbl[9]  = mk("down_from_limit",    B_DOWN,        1'b0, ex(0, 0, 3'b010, 5'd20));
    tbl[10] = mk("down_in_run_down",   B_DOWN,        1'b0, ex(0, 0, 3'b010, 5'd20));
    tbl[11] = mk("limit_in_down",      B_NONE,        1'b1, ex(1, 0, 3'b001, 5'd20));
    tbl[12] = mk("down_in_limit_down", B_DOWN,        1'b0, ex(1, 0, 3'b001, 5'd20));
    tbl[13] = mk("up_from_limit_down", B_UP,          1'b0, ex(0, 1, 3'b100, 5'd20));
    tbl[14] = mk("stop_down_together", B_STOP|B_DOWN, 1'b0, ex(1, 1, 3'b000, 5'd20));
    tbl[15] = mk("down_from_stopped",  B_DOWN,        1'b0, ex(0, 0, 3'b010, 5'd20));
    tbl[16] = mk("clear_up_together",  B_CLEAR|B_UP,  1'b0, ex(1, 1, 3'b000, 5'd20));
    tbl[17] = mk("faster",             B_FAST,        1'b0, ex(1, 1, 3'b000, 5'd19));
    tbl[18] = mk("slower",             B_SLOW,        1'b0, ex(1, 1, 3'b000, 5'd20));
    tbl[19] = mk("faster_slower",      B_FAST|B_SLOW, 1'b0, ex(1, 1, 3'b000, 5'd20));
    tbl[20] = mk("stop_up_in_stopped", B_STOP|B_UP,   1'b0, ex(1, 1, 3'b000, 5'd20));

    set_btn(B_NONE);
    sw.LimitReached = 1'b0;
    Reset = 1'b0;
    cycles(3);
    check("reset_outputs", 32'(obs()), 32'(ex(1, 1, 3'b000, 5'd20)));
    check("reset_counter_reset", 32'(sw.CounterReset), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    Reset = 1'b1;
    cycles(2);

    // press latency: first sample at edge N, outputs move at edge N+LAT
    set_btn(B_UP);
    @(posedge Clk);
    repeat (LAT - 1) @(posedge Clk);
    #1;
    check("latency_before", 32'(sw.ModeUp), 32'd0);
    @(posedge Clk);
    #1;
    check("latency_at", 32'(obs()), 32'(ex(0, 1, 3'b100, 5'd20)));
    cycles(HOLD - LAT);
    set_btn(B_NONE);
    cycles(GAP);

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].lim) begin
        sw.LimitReached = 1'b1;
        cycles(1);
        sw.LimitReached = 1'b0;
      end
      if (tbl[i].btn != B_NONE) press(tbl[i].btn, HOLD, 0);
      cycles(GAP);
      check(tbl[i].name, 32'(obs()), 32'(tbl[i].exp));
    end

    // Clear from RUN_UP: exactly one CounterReset pulse, together with CounterStop rising
    press(B_UP, HOLD, GAP);
    check("clear_setup_run_up", 32'(obs()), 32'(ex(0, 1, 3'b100, 5'd20)));
    pulses    = 0;
    bad_stop  = 0;
    prev_stop = sw.CounterStop;
    set_btn(B_CLEAR);
    for (int i = 0; i < HOLD + GAP; i++) begin
      if (i == HOLD) set_btn(B_NONE);
      cycles(1);
      if (sw.CounterReset) begin
        pulses++;
        if (!sw.CounterStop || prev_stop) bad_stop++;
      end
      prev_stop = sw.CounterStop;
    end
    check("clear_pulse_count", 32'(pulses), 32'd1);
    check("clear_pulse_with_stop_edge", 32'(bad_stop), 32'd0);
    check("clear_state", 32'(obs()), 32'(ex(1, 1, 3'b000, 5'd20)));

    // LimitReached high at edge M -> stop after edge M+1
    press(B_UP, HOLD, GAP);
    sw.LimitReached = 1'b1;
    @(posedge Clk);
    #1;
    sw.LimitReached = 1'b0;
    check("limit_edge_m", 32'(sw.CounterStop), 32'd0);
    @(posedge Clk);
    #1;
    check("limit_edge_m1", 32'({sw.CounterStop, sw.ModeLimit}), 32'd3);
    press(B_STOP, HOLD, GAP);

    // speed saturation
    for (int i = 0; i < 25; i++) press(B_SLOW, TAP, TAP);
    cycles(GAP);
    check("speed_sat_high", 32'(sw.Speed), 32'd31);
    for (int i = 0; i < 40; i++) press(B_FAST, TAP, TAP);
    cycles(GAP);
    check("speed_sat_low", 32'(sw.Speed), 32'd0);
    press(B_FAST|B_SLOW, HOLD, GAP);
    check("speed_both_at_zero", 32'(sw.Speed), 32'd0);
    press(B_SLOW, HOLD, GAP);
    press(B_FAST|B_SLOW, HOLD, GAP);
    check("speed_both_at_one", 32'(sw.Speed), 32'd1);

    // asynchronous reset mid-RUN_UP, checked before any clock edge
    press(B_UP, HOLD, GAP);
    check("pre_reset_run_up", 32'(obs()), 32'(ex(0, 1, 3'b100, 5'd1)));
    @(negedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    check("async_reset_outputs", 32'(obs()), 32'(ex(1, 1, 3'b000, 5'd20)));
    check("async_reset_state", 32'(dbg_state), 32'd0);
    cycles(2);
    Reset = 1'b1;
    cycles(2);

`ifdef STOPWATCH_CONTROLLER_DEBOUNCE_EN
    // bounces one sample short of the filter length never produce an event
    for (int i = 0; i < 3; i++) press(B_UP, DEB - 1, 3);
    cycles(GAP);
    check("debounce_bounce_ignored", 32'(obs()), 32'(ex(1, 1, 3'b000, 5'd20)));
    press(B_UP, DEB, GAP);
    check("debounce_hold_accepted", 32'(obs()), 32'(ex(0, 1, 3'b100, 5'd20)));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Mode and speed sequencer for the stopwatch datapath. It takes raw push-button inputs and the up/down counter's limit flag, and drives the counter's stop, direction and reset controls plus the clock divider's 5-bit speed exponent. It sits between the board buttons and the counter/divider pair, replacing ad-hoc mode logic with a defined state machine, input synchronisation and optional debouncing.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a debounced level changes. Minimum 1; the counter width is derived from it.
- SPEED_RESET, 20: value of Speed after reset. Must be 0..31.
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- BtnStop, BtnUp, BtnDown, BtnClear  in  1 each  raw, asynchronous mode buttons, active-high.
- BtnFaster, BtnSlower  in  1 each  raw, asynchronous speed buttons, active-high.
- LimitReached  in  1  counter limit flag, synchronous to Clk.
- CounterStop  out  1  1 = hold the counter.
- CounterUpDown  out  1  1 = count up, 0 = count down.
- CounterReset  out  1  one-cycle clear pulse to the counter.
- Speed  out  5  divider exponent; the divide factor is 2^Speed, so a larger value is slower.
- ModeUp, ModeDown, ModeLimit  out  1 each  mode indicator LEDs; registered and one-hot or all zero.

## Operation
- **Input path.** Every Btn* input passes through a 2-flop synchroniser, then the optional debounce filter, then a rising-edge detector. The detector produces a one-cycle press event per button. A held button produces exactly one event.
- **FSM states.** STOPPED, RUN_UP, RUN_DOWN, LIMIT, with a direction register Dir (1 = up).
- **Event priority** when events coincide in one cycle: Clear > Stop > Up > Down > LimitReached. Lower-priority events in that cycle are discarded.
- **Clear**, from any state: CounterReset = 1 for exactly one cycle, next state STOPPED, Dir = 1. Speed is unchanged.
- **STOPPED**
  - Up -> RUN_UP, Dir = 1.
  - Down -> RUN_DOWN, Dir = 0.
  - Stop and LimitReached are ignored.
- **RUN_UP / RUN_DOWN**
  - Stop -> STOPPED.
  - Opposite-direction button -> the other RUN state.
  - Same-direction button is ignored.
  - LimitReached = 1 -> LIMIT.
- **LIMIT**
  - Button opposite to Dir -> that RUN state.
  - Same-direction button is ignored.
  - Stop -> STOPPED.
  - LimitReached is ignored.
- **Output decode** (registered from the next state):
  - CounterStop = 1 in STOPPED and LIMIT.
  - CounterUpDown = Dir.
  - ModeUp = RUN_UP, ModeDown = RUN_DOWN, ModeLimit = LIMIT.
- **Speed control** operates independently of the FSM state.
  - Faster: Speed − 1, saturating at 0.
  - Slower: Speed + 1, saturating at 31.
  - Faster and Slower in the same cycle: no change.
- **Reset values.** State STOPPED, Dir = 1, CounterStop = 1, CounterUpDown = 1, CounterReset = 0, Speed = SPEED_RESET, all Mode* = 0. All synchroniser, filter and edge registers clear to 0.
- **Reset asserted mid-run.** All outputs return to their reset values immediately, without waiting for a clock edge.

## Timing
- The synchroniser and edge detector add 3 cycles before the FSM sees an event. With a raw input first sampled high at edge N and no debounce, the event pulse is high during cycle N+2 and the outputs change at edge N+3.
- With debounce enabled, add DEBOUNCE_CYCLES cycles to that latency.
- CounterReset is high for exactly one cycle, coincident with the transition of CounterStop to 1.
- LimitReached, sampled high at edge M while in a RUN state, gives CounterStop = 1 and ModeLimit = 1 after edge M+1. The counter therefore sees at most one extra enable cycle after the limit.
- Speed updates on the same edge as the mode outputs for the same press.

## Configuration
- Macro: STOPWATCH_CONTROLLER_DEBOUNCE_EN.
- **Defined:** each synchronised input feeds a counter.
  - The debounced level flips only after DEBOUNCE_CYCLES consecutive samples that differ from the current level.
  - Any sample equal to the current level zeroes the counter.
- **Undefined:** the debounced level equals the synchroniser output. DEBOUNCE_CYCLES is ignored and no filter counter is synthesised.

## Test plan
- **Reset:** Reset = 0 mid-RUN_UP -> outputs immediately become CounterStop = 1, CounterUpDown = 1, Speed = 20, Mode* = 0, with no clock edge.
- **Sequence and latency:** debounce off; pulse BtnUp, then BtnDown, then BtnStop (each held 5 cycles) -> ModeUp at N+3 after the first sample, then ModeDown, then all Mode* = 0. Exactly one transition per press.
- **Limit:** in RUN_UP, drive LimitReached = 1 -> LIMIT, CounterStop = 1, ModeLimit = 1. BtnUp is then ignored; BtnDown -> RUN_DOWN with CounterUpDown = 0.
- **Simultaneous buttons:** BtnClear and BtnUp in the same cycle -> one-cycle CounterReset, state STOPPED. BtnStop and BtnDown together in RUN_UP -> STOPPED.
- **Speed saturation:** 25 Slower presses from 20 -> Speed stays at 31. 40 Faster presses -> Speed stays at 0. Faster and Slower together -> no change.
- **Debounce on:** DEBOUNCE_CYCLES = 8; bounce BtnUp high for 7 cycles then low, repeated -> no event. Hold it high for 8 cycles -> exactly one RUN_UP transition.
